// File: rtl/voice_allocator_if.sv
// Note-event handshake and per-voice output bundle for voice_allocator.
interface voice_allocator_if #(
    parameter int NUM_VOICES = 4
);
    logic                       ev_valid;
    logic                       ev_ready;
    logic                       ev_on;
    logic [6:0]                 ev_note;
    logic                       all_off;
    logic [NUM_VOICES-1:0][6:0] freq;
    logic [NUM_VOICES-1:0]      key_on;
    logic [2:0]                 active_cnt;
    logic                       drop;

    modport master (
        output ev_valid, ev_on, ev_note, all_off,
        input  ev_ready, freq, key_on, active_cnt, drop
    );

    modport slave (
        input  ev_valid, ev_on, ev_note, all_off,
        output ev_ready, freq, key_on, active_cnt, drop
    );
endinterface

// File: rtl/voice_allocator.sv
// Four-voice note allocator: IDLE/SCAN/COMMIT event FSM with LRU ages.
// Optional macro VOICE_STEAL_EN: steal the oldest voice when all are busy.
module voice_allocator #(
    parameter int NUM_VOICES = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    voice_allocator_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
    typedef enum logic [1:0] {ACT_NONE, ACT_ON, ACT_OFF, ACT_DROP} act_t;

    state_t                     state_q, state_d;
    act_t                       act_q, act_d;
    logic                       on_q, on_d;
    logic [6:0]                 note_q, note_d;
    logic [1:0]                 tgt_q, tgt_d;
    logic [NUM_VOICES-1:0]      key_on_q, key_on_d;
    logic [NUM_VOICES-1:0][6:0] freq_q, freq_d;
    logic [NUM_VOICES-1:0][1:0] age_q, age_d;
    logic [2:0]                 cnt_q, cnt_d;
    logic                       drop_c;

    logic [NUM_VOICES-1:0]      hit_v;
    logic [NUM_VOICES-1:0]      free_v;
    logic [NUM_VOICES-1:0]      old_v;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        assign hit_v[v]  = key_on_q[v] && (freq_q[v] == note_q);
        assign free_v[v] = !key_on_q[v];
        assign old_v[v]  = (age_q[v] == 2'd3);
    end

    function automatic logic [1:0] first_idx(input logic [NUM_VOICES-1:0] m);
        logic [1:0] idx;
        idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (m[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    always_comb begin
        state_d  = state_q;
        act_d    = act_q;
        on_d     = on_q;
        note_d   = note_q;
        tgt_d    = tgt_q;
        key_on_d = key_on_q;
        freq_d   = freq_q;
        age_d    = age_q;
        drop_c   = 1'b0;
        cnt_d    = '0;

        case (state_q)
            IDLE: begin
                if (bus.ev_valid) begin
                    on_d    = bus.ev_on;
                    note_d  = bus.ev_note;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                act_d = ACT_NONE;
                if (on_q) begin
                    if (|hit_v) begin
                        tgt_d = first_idx(hit_v);
                        act_d = ACT_ON;
                    end else if (|free_v) begin
                        tgt_d = first_idx(free_v);
                        act_d = ACT_ON;
                    end else begin
`ifdef VOICE_STEAL_EN
                        tgt_d = first_idx(old_v);
                        act_d = ACT_ON;
`else
                        act_d = ACT_DROP;
`endif
                    end
                end else if (|hit_v) begin
                    tgt_d = first_idx(hit_v);
                    act_d = ACT_OFF;
                end
                state_d = COMMIT;
            end
            COMMIT: begin
                case (act_q)
                    ACT_ON: begin
                        // Retrigger and steal reuse this path; key_on is never dropped.
                        key_on_d[tgt_q] = 1'b1;
                        freq_d[tgt_q]   = note_q;
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (2'(i) == tgt_q)
                                age_d[i] = 2'd0;
                            else if (age_q[i] < age_q[tgt_q])
                                age_d[i] = age_q[i] + 2'd1;
                        end
                    end
                    ACT_OFF:  key_on_d[tgt_q] = 1'b0;
                    ACT_DROP: drop_c = 1'b1;
                    default:  ;
                endcase
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Panic overrides any accepted or in-flight event, silently.
        if (bus.all_off) begin
            key_on_d = '0;
            state_d  = IDLE;
            drop_c   = 1'b0;
        end

        for (int i = 0; i < NUM_VOICES; i++)
            cnt_d = cnt_d + {2'b00, key_on_d[i]};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            act_q    <= ACT_NONE;
            on_q     <= 1'b0;
            note_q   <= '0;
            tgt_q    <= '0;
            key_on_q <= '0;
            freq_q   <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < NUM_VOICES; i++)
                age_q[i] <= 2'(i);
        end else begin
            state_q  <= state_d;
            act_q    <= act_d;
            on_q     <= on_d;
            note_q   <= note_d;
            tgt_q    <= tgt_d;
            key_on_q <= key_on_d;
            freq_q   <= freq_d;
            age_q    <= age_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.ev_ready   = (state_q == IDLE);
    assign bus.freq       = freq_q;
    assign bus.key_on     = key_on_q;
    assign bus.active_cnt = cnt_q;
    assign bus.drop       = drop_c;

endmodule
